timer_tick_sched: RTL and testbench
===================================

# timer_tick_sched

Downstream consumer of the 100 µs toggle timebase. Converts each toggle of `timer_100us_i` into a single-cycle 100 µs tick. Runs a programmable one-shot/periodic countdown in units of those ticks and raises an expiry pulse plus a sticky interrupt flag with acknowledge. Sits between the timebase divider and control logic that needs ms-scale timeouts or periodic events.

## Interface
Parameters:
- `CNT_W`, default 16: width of the period and remaining-count fields, in 100 µs units.

Ports:
- `clk_i`, input, 1: system clock. Same clock as the timebase divider.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `timer_100us_i`, input, 1: toggle from the timebase divider. Each level change marks one 100 µs interval. Synchronous to `clk_i`.
- `start_i`, input, 1: single-cycle pulse. Latches `period_i` and `mode_i`, then starts or restarts the countdown.
- `stop_i`, input, 1: single-cycle pulse. Aborts the countdown.
- `mode_i`, input, 1: 0 selects one-shot, 1 selects periodic. Sampled only on `start_i`.
- `period_i`, input, CNT_W: countdown length in ticks. Sampled only on `start_i`.
- `ack_i`, input, 1: clears `irq_o` and `overrun_o`.
- `tick_100us_o`, output, 1: one-cycle pulse per input toggle.
- `busy_o`, output, 1: high while in the RUN state.
- `count_o`, output, CNT_W: remaining ticks. 0 when idle.
- `expire_o`, output, 1: one-cycle pulse when the count reaches 0.
- `irq_o`, output, 1: sticky expiry flag.
- `overrun_o`, output, 1: sticky flag. Set when an expiry occurs while `irq_o` is still set.

## Operation
- **Edge detect**
  - `prev` register holds the last sampled `timer_100us_i`.
  - `primed` bit is cleared by reset and set after the first sample.
  - Internal tick_c = primed & (timer_100us_i != prev).
  - The first sample after reset never generates a tick.
  - `tick_100us_o` is tick_c registered.
- **State machine**: IDLE and RUN.
- **In IDLE**
  - `start_i` with `period_i` != 0: load count = period_i, latch period and mode, go to RUN.
  - `start_i` with `period_i` == 0: ignored; state stays IDLE.
- **In RUN, on tick_c**
  - If count > 1: count decrements.
  - If count == 1: `expire_o` fires.
    - Periodic mode: count reloads from the latched period; state stays RUN.
    - One-shot mode: count goes to 0; state goes to IDLE.
- **`start_i` in RUN**: restart. Reloads from the new `period_i` and `mode_i`. A tick_c in the same cycle is discarded. `period_i` == 0 acts as stop.
- **`stop_i`**: go to IDLE, count = 0, no expiry.
- **Priority**: stop_i > start_i > tick_c.
  - `stop_i` in the same cycle as a final tick: no `expire_o`, no `irq_o`.
- **Flags**
  - `irq_o` is set on expiry and cleared by `ack_i`. Set wins when both occur in the same cycle.
  - `overrun_o` is set on expiry when `irq_o` is already 1 and `ack_i` is 0. It is cleared by `ack_i`. Set wins when both occur in the same cycle.
- **Width**: count arithmetic is unsigned CNT_W. Maximum period is 2^CNT_W − 1 ticks. No wrap occurs, because reload happens at count == 1.
- **Reset mid-operation**: returns to IDLE, clears all flags, re-arms the priming of the edge detector.

## Timing
- Reset values: `tick_100us_o`=0, `busy_o`=0, `count_o`=0, `expire_o`=0, `irq_o`=0, `overrun_o`=0. Internally, state=IDLE and primed=0.
- All outputs are registered.
- **Tick latency**: `timer_100us_i` changes in cycle N; `tick_100us_o` is high in cycle N+1 only.
- **Count and expiry alignment**
  - `count_o` and `busy_o` update in the same cycle that `tick_100us_o` is high.
  - `expire_o` and the rising edge of `irq_o` coincide with that same `tick_100us_o` pulse.
- **Start latency**: `start_i` in cycle N gives `busy_o`=1 and `count_o`=period in cycle N+1.
- **Expiry spacing**: a period of P expires on the P-th tick after start. In periodic mode, successive `expire_o` pulses are exactly P ticks apart.
- **Stop latency**: `stop_i` in cycle N gives `busy_o`=0 and `count_o`=0 in cycle N+1.
- **`ack_i`**: `ack_i` in cycle N gives `irq_o`=0 in cycle N+1, unless an expiry occurs in cycle N.
- **Input restriction**: `timer_100us_i` must hold each level for at least 2 clocks. Faster toggling is outside spec.

## Test plan
- **Reset and priming**: hold `timer_100us_i`=1 through reset, then release reset -> no `tick_100us_o`. Next toggle -> exactly one 1-cycle tick, one cycle after the toggle.
- **One-shot**: toggle the input every 10 clocks, start with period=3, mode=0 -> `count_o` goes 3,2,1,0. `expire_o` fires once on the 3rd tick. `busy_o`=0 afterwards, `irq_o`=1 until `ack_i`.
- **Periodic plus overrun**: period=2, mode=1, no ack -> `expire_o` on ticks 2, 4, 6. `overrun_o` set at tick 4. `ack_i` clears both flags. Expiry with `ack_i` in the same cycle -> `irq_o` stays 1.
- **Stop on final tick**: period=1, `stop_i` in the same cycle as tick_c -> no `expire_o`, `irq_o`=0, `busy_o`=0.
- **Restart**: in RUN with count=5, `start_i` with period=4 in the same cycle as a tick -> `count_o`=4 next cycle, and the tick is not counted.
- **Edge cases**: `start_i` with period=0 in IDLE -> `busy_o` stays 0. Period=0xFFFF -> counts down without wrap. `rst_i` mid-RUN -> all outputs return to 0.

Source files
------------

// File: rtl/timer_tick_sched.sv
`default_nettype none
// ============================================================================
// timer_tick_sched : 100 us toggle -> tick, one-shot/periodic countdown + irq
// Revision: 1.0
// ============================================================================
module timer_tick_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             timer_100us_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             ack_i,
  output logic             tick_100us_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o,
  output logic             irq_o,
  output logic             overrun_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             tick_q, tick_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             tick_c;

  // The first sample after reset only primes prev; it can never form a tick.
  always_comb begin
    prev_d   = timer_100us_i;
    primed_d = 1'b1;
    tick_c   = primed_q & (timer_100us_i != prev_q);
    tick_d   = tick_c;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
      count_d = CNT_ZERO;
    end else if (start_i) begin
      if (period_i != CNT_ZERO) begin
        state_d  = ST_RUN;
        count_d  = period_i;
        period_d = period_i;
        mode_d   = mode_i;
      end else begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    end else if ((state_q == ST_RUN) && tick_c) begin
      // Reload happens at 1, so the count never passes through 0 while running.
      if (count_q == CNT_ONE) begin
        expire_d = 1'b1;
        if (mode_q) begin
          count_d = period_q;
        end else begin
          count_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (ack_i) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (expire_d) begin
      irq_d = 1'b1;
      if (irq_q && !ack_i) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b0;
      primed_q  <= 1'b0;
      tick_q    <= 1'b0;
      expire_q  <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= 1'b0;
      count_q   <= CNT_ZERO;
      period_q  <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      tick_q    <= tick_d;
      expire_q  <= expire_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      period_q  <= period_d;
    end
  end

  assign tick_100us_o = tick_q;
  assign busy_o       = (state_q == ST_RUN);
  assign count_o      = count_q;
  assign expire_o     = expire_q;
  assign irq_o        = irq_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_tick_sched.sv
`default_nettype none
// ============================================================================
// tb_timer_tick_sched : directed vector table plus periodic spacing sequence
// Revision: 1.0
// ============================================================================
module tb_timer_tick_sched;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        timer_100us_i;
  logic        start_i;
  logic        stop_i;
  logic        mode_i;
  logic [15:0] period_i;
  logic        ack_i;
  logic        tick_100us_o;
  logic        busy_o;
  logic [15:0] count_o;
  logic        expire_o;
  logic        irq_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;

  timer_tick_sched #(.CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .timer_100us_i (timer_100us_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .mode_i        (mode_i),
    .period_i      (period_i),
    .ack_i         (ack_i),
    .tick_100us_o  (tick_100us_o),
    .busy_o        (busy_o),
    .count_o       (count_o),
    .expire_o      (expire_o),
    .irq_o         (irq_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, tmr, start, stop, mode;
    logic [15:0] period;
    logic        ack;
    logic        tick, busy;
    logic [15:0] count;
    logic        expire, irq, ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, tmr, start, stop, mode, input logic [15:0] period,
                     input logic ack, tick, busy, input logic [15:0] count,
                     input logic expire, irq, ovr);
    vec_t v;
    v.rst = rst; v.tmr = tmr; v.start = start; v.stop = stop; v.mode = mode;
    v.period = period; v.ack = ack; v.tick = tick; v.busy = busy; v.count = count;
    v.expire = expire; v.irq = irq; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    int exp_cnt;
    int last_exp;
    int tick_cnt;
    logic prev_tick;

    rst_i = 1'b1; timer_100us_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    mode_i = 1'b0; period_i = '0; ack_i = 1'b0;

    //   rst tmr st sp md period  ack | tick busy count  exp irq ovr
    add(1, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // reset, input held high
    add(1, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // priming sample
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 0, 16'd0, 0, 0, 0);   // first real toggle
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'd3, 0,   0, 1, 16'd3, 0, 0, 0);   // one-shot P=3
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 1, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'd2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 0, 16'd0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 16'd0, 1,   0, 0, 16'd0, 0, 0, 0);   // ack
    add(0, 1, 1, 0, 1, 16'd2, 0,   0, 1, 16'd2, 0, 0, 0);   // periodic P=2
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 1, 16'd2, 1, 1, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'd2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 1, 16'd2, 1, 1, 1);   // overrun
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'd2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd1, 0, 1, 1);
    add(0, 1, 0, 0, 0, 16'd0, 1,   1, 1, 16'd2, 1, 1, 0);   // expiry + ack: irq stays
    add(0, 1, 0, 0, 0, 16'd0, 1,   0, 1, 16'd2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'd2, 0, 0, 0);
    add(0, 1, 0, 1, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // stop
    add(0, 1, 1, 0, 0, 16'd1, 0,   0, 1, 16'd1, 0, 0, 0);   // P=1
    add(0, 0, 0, 1, 0, 16'd0, 0,   1, 0, 16'd0, 0, 0, 0);   // stop on final tick
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'd5, 0,   0, 1, 16'd5, 0, 0, 0);   // P=5
    add(0, 1, 1, 0, 0, 16'd4, 0,   1, 1, 16'd4, 0, 0, 0);   // restart with tick
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'd4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // start P=0 in RUN
    add(0, 0, 1, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // start P=0 in IDLE
    add(0, 0, 1, 0, 0, 16'hFFFF, 0, 0, 1, 16'hFFFF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 1, 16'hFFFE, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 1, 16'hFFFE, 0, 0, 0);
    add(0, 1, 1, 0, 1, 16'd1, 0,   0, 1, 16'd1, 0, 0, 0);   // periodic P=1
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   0, 1, 16'd1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 16'd0, 0,   1, 1, 16'd1, 1, 1, 1);
    add(1, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // reset mid-RUN
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);   // re-primed, no tick
    add(0, 1, 0, 0, 0, 16'd0, 0,   0, 0, 16'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 16'd0, 0,   1, 0, 16'd0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_i = tbl[i].rst; timer_100us_i = tbl[i].tmr; start_i = tbl[i].start;
      stop_i = tbl[i].stop; mode_i = tbl[i].mode; period_i = tbl[i].period;
      ack_i = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d.tick", i),    32'(tick_100us_o), 32'(tbl[i].tick));
      chk($sformatf("row%0d.busy", i),    32'(busy_o),       32'(tbl[i].busy));
      chk($sformatf("row%0d.count", i),   32'(count_o),      32'(tbl[i].count));
      chk($sformatf("row%0d.expire", i),  32'(expire_o),     32'(tbl[i].expire));
      chk($sformatf("row%0d.irq", i),     32'(irq_o),        32'(tbl[i].irq));
      chk($sformatf("row%0d.overrun", i), 32'(overrun_o),    32'(tbl[i].ovr));
    end

    // Periodic P=3 with a toggle every 4 clocks: expiries exactly 12 clocks apart.
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b1; period_i = 16'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0; period_i = '0;
    exp_cnt = 0; last_exp = -1; tick_cnt = 0; prev_tick = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((i % 4) == 3) timer_100us_i = ~timer_100us_i;
      @(posedge clk);
      #1;
      if (tick_100us_o) tick_cnt++;
      if (tick_100us_o && prev_tick) chk($sformatf("seq.tick_width@%0d", i), 32'd2, 32'd1);
      prev_tick = tick_100us_o;
      if (expire_o) begin
        if (last_exp < 0) chk("seq.first_expire", 32'(i), 32'd11);
        else              chk("seq.expire_spacing", 32'(i - last_exp), 32'd12);
        last_exp = i;
        exp_cnt++;
      end
    end
    chk("seq.tick_count", 32'(tick_cnt), 32'd20);
    chk("seq.expire_count", 32'(exp_cnt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
